// File: rtl/vid_sync_decoder.sv
// Video sync decoder: measures sync timing, tracks lock and emits
// pixel coordinates aligned with the delayed pixel stream.
module vid_sync_decoder #(
    parameter int W           = 11,
    parameter int LOCK_FRAMES = 2,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         de_in,
    input  logic [11:0]  rgb_in,
    output logic [11:0]  rgb_out,
    output logic         de_out,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         frame_start,
    output logic [W-1:0] h_total,
    output logic [W-1:0] h_active,
    output logic [W-1:0] v_total,
    output logic [W-1:0] v_active,
    output logic         locked,
    output logic         overflow
);
    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_e;

    localparam logic [W-1:0] MAX = '1;
    localparam logic [3:0]   LF  = 4'(LOCK_FRAMES);

    state_e state_q, state_d;
    logic [3:0] match_q, match_d;

    logic hs_q, vs_q, de_q, hs_p_q, vs_p_q;
    logic [11:0] rgb_q, rgb_out_q;
    logic de_out_q, fs_q, fs_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0] hcnt_q, hcnt_d, hacnt_q, hacnt_d;
    logic [W-1:0] vcnt_q, vcnt_d, vacnt_q, vacnt_d;
    logic line_de_q, line_de_d, frame_de_q, frame_de_d;
    logic [W-1:0] ht_q, ht_d, ha_q, ha_d, vt_q, vt_d, va_q, va_d;
    logic [W-1:0] ref_ht_q, ref_ht_d, ref_ha_q, ref_ha_d;
    logic ref_ok_q, ref_ok_d, ovf_q, ovf_d;

    logic hs_edge, vs_edge, first_de, new_frame, fmatch, h_change;
    logic ov_h, ov_ha, ov_v, ov_va, ov_x, ov_y;
    logic [W-1:0] hcnt_inc, hacnt_inc, vcnt_n, vacnt_inc, x_inc, y_inc;

    function automatic logic [W:0] sinc(input logic [W-1:0] v,
                                        input logic en);
        if (en && v == MAX) return {1'b1, MAX};
        return {1'b0, v + W'(en)};
    endfunction

    assign hs_edge   = (hs_q == HS_POL) && (hs_p_q != HS_POL);
    assign vs_edge   = (vs_q == VS_POL) && (vs_p_q != VS_POL);
    assign first_de  = de_q && (!line_de_q || hs_edge);
    assign new_frame = vs_edge || !frame_de_q;

    // A coincident hsync edge closes its line before the frame is closed.
    always_comb begin
        {ov_h, hcnt_inc}   = sinc(hcnt_q, 1'b1);
        {ov_ha, hacnt_inc} = sinc(hacnt_q, de_q);
        {ov_v, vcnt_n}     = sinc(vcnt_q, hs_edge);
        {ov_va, vacnt_inc} = sinc(vacnt_q, first_de);
        {ov_x, x_inc}      = sinc(x_q, 1'b1);
        {ov_y, y_inc}      = sinc(y_q, 1'b1);

        hcnt_d  = hs_edge ? W'(1) : hcnt_inc;
        hacnt_d = hs_edge ? W'(de_q) : hacnt_inc;
        ht_d    = hs_edge ? hcnt_q : ht_q;
        ha_d    = hs_edge ? hacnt_q : ha_q;
        vcnt_d  = vs_edge ? '0 : vcnt_n;
        vacnt_d = vs_edge ? W'(first_de) : vacnt_inc;
        vt_d    = vs_edge ? vcnt_n : vt_q;
        va_d    = vs_edge ? vacnt_q : va_q;

        line_de_d  = hs_edge ? de_q : (line_de_q | de_q);
        frame_de_d = vs_edge ? first_de : (frame_de_q | first_de);

        x_d  = de_q ? (first_de ? '0 : x_inc) : x_q;
        y_d  = first_de ? (new_frame ? '0 : y_inc) : y_q;
        fs_d = first_de && new_frame && (state_q == S_LOCKED);

        fmatch   = (ht_d == ref_ht_q) && (ha_d == ref_ha_q) &&
                   (vcnt_n == vt_q) && (vacnt_q == va_q);
        h_change = hs_edge && (hcnt_q != ht_q);

        ref_ht_d = vs_edge ? ht_d : ref_ht_q;
        ref_ha_d = vs_edge ? ha_d : ref_ha_q;
        ref_ok_d = vs_edge ? (state_q != S_SEARCH) : ref_ok_q;

        ovf_d = ovf_q | (ov_h & ~hs_edge) | (ov_ha & ~hs_edge) | ov_v |
                (ov_va & ~vs_edge) | (ov_x & de_q & ~first_de) |
                (ov_y & first_de & ~new_frame);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SEARCH;
            match_q <= '0;
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0;
            hs_p_q <= 1'b0; vs_p_q <= 1'b0;
            rgb_q <= '0; rgb_out_q <= '0;
            de_out_q <= 1'b0; fs_q <= 1'b0;
            x_q <= '0; y_q <= '0;
            hcnt_q <= '0; hacnt_q <= '0;
            vcnt_q <= '0; vacnt_q <= '0;
            line_de_q <= 1'b0; frame_de_q <= 1'b0;
            ht_q <= '0; ha_q <= '0; vt_q <= '0; va_q <= '0;
            ref_ht_q <= '0; ref_ha_q <= '0;
            ref_ok_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            hs_q <= hsync_in; vs_q <= vsync_in; de_q <= de_in;
            hs_p_q <= hs_q; vs_p_q <= vs_q;
            rgb_q <= rgb_in; rgb_out_q <= rgb_q;
            de_out_q <= de_q; fs_q <= fs_d;
            x_q <= x_d; y_q <= y_d;
            hcnt_q <= hcnt_d; hacnt_q <= hacnt_d;
            vcnt_q <= vcnt_d; vacnt_q <= vacnt_d;
            line_de_q <= line_de_d; frame_de_q <= frame_de_d;
            ht_q <= ht_d; ha_q <= ha_d; vt_q <= vt_d; va_q <= va_d;
            ref_ht_q <= ref_ht_d; ref_ha_q <= ref_ha_d;
            ref_ok_q <= ref_ok_d; ovf_q <= ovf_d;
        end
    end

    // The first valid frame after SEARCH counts as the first match.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        unique case (state_q)
            S_SEARCH: begin
                if (vs_edge) begin
                    state_d = S_TRACK;
                    match_d = '0;
                end
            end
            S_TRACK: begin
                if (vs_edge) begin
                    if (!ref_ok_q) match_d = 4'd1;
                    else if (fmatch)
                        match_d = (match_q >= LF) ? LF : match_q + 4'd1;
                    else match_d = '0;
                    if (match_d >= LF && !ovf_q) state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (ovf_q || h_change || (vs_edge && !fmatch)) begin
                    state_d = S_TRACK;
                    match_d = '0;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_comb begin
        locked = (state_q == S_LOCKED);
    end

    assign rgb_out     = rgb_out_q;
    assign de_out      = de_out_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign h_total     = ht_q;
    assign h_active    = ha_q;
    assign v_total     = vt_q;
    assign v_active    = va_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_vid_sync_decoder.sv
// Directed bench for vid_sync_decoder using an 800-clk line
// with a short 6-line frame (4 active lines, vsync on line 4).
module tb_vid_sync_decoder;
    localparam int W   = 11;
    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int H0  = 144;
    localparam int HSW = 96;
    localparam int VA  = 4;
    localparam int VSL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic hsync_in = 1'b1;
    logic vsync_in = 1'b1;
    logic de_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [11:0] rgb_out;
    logic de_out, frame_start, locked, overflow;
    logic [W-1:0] x, y, h_total, h_active, v_total, v_active;

    int total = 0;
    int passed = 0;
    int fails = 0;
    bit fs_exp = 1'b0;

    vid_sync_decoder #(
        .W(W), .LOCK_FRAMES(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .rgb_in(rgb_in),
        .rgb_out(rgb_out), .de_out(de_out),
        .x(x), .y(y), .frame_start(frame_start),
        .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active),
        .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_line(input int ln, input int len,
                            input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            @(negedge clk);
            if (ln == 0 && c == H0 + 2) begin
                chk("x_first", 32'(x), 0);
                chk("y_first", 32'(y), 0);
                chk("frame_start", 32'(frame_start), 32'(fs_exp));
            end
            if (ln == VA - 1 && c == H0 + HA + 1) begin
                chk("x_last", 32'(x), 639);
                chk("y_last", 32'(y), VA - 1);
                chk("rgb_last", 32'(rgb_out), 32'h0ABC);
                chk("de_last", 32'(de_out), 1);
            end
            if (ln == VA - 1 && c == H0 + HA + 6) begin
                chk("x_hold", 32'(x), 639);
                chk("de_off", 32'(de_out), 0);
            end
            hsync_in = (c < HSW) ? 1'b0 : 1'b1;
            vsync_in = (ln == VSL) ? 1'b0 : 1'b1;
            de_in = (ln < VA) && (c >= H0) && (c < H0 + HA);
            rgb_in = (ln == VA - 1 && c == H0 + HA - 1) ?
                     12'hABC : 12'(c);
        end
    endtask

    task automatic frame(input int l0, input int l1);
        for (int l = l0; l <= l1; l++) run_line(l, HT, 0, HT);
    endtask

    task automatic chk_meas(input string tag);
        chk({tag, "_ht"}, 32'(h_total), HT);
        chk({tag, "_ha"}, 32'(h_active), HA);
        chk({tag, "_vt"}, 32'(v_total), 6);
        chk({tag, "_va"}, 32'(v_active), VA);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_any", 32'(|{rgb_out, de_out, x, y, frame_start,
            h_total, h_active, v_total, v_active, locked, overflow}), 0);
        chk("rst_locked", 32'(locked), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fs_exp = 1'b0;
        frame(0, 5);
        frame(0, 4);
        chk_meas("f2");
        chk("f2_lock", 32'(locked), 0);
        frame(5, 5);
        frame(0, 3);
        chk("f3_prelock", 32'(locked), 0);
        frame(4, 4);
        chk("f3_lock", 32'(locked), 1);
        chk("f3_ovf", 32'(overflow), 0);
        chk_meas("f3");
        frame(5, 5);

        fs_exp = 1'b1;
        frame(0, 1);
        fs_exp = 1'b0;
        run_line(2, HT + 1, 0, HT + 1);
        run_line(3, HT, 0, 2);
        chk("stretch_hold", 32'(locked), 1);
        run_line(3, HT, 2, 3);
        chk("stretch_drop", 32'(locked), 0);
        chk("stretch_ht", 32'(h_total), HT + 1);
        run_line(3, HT, 3, HT);
        frame(4, 4);
        chk("relock_1", 32'(locked), 0);
        frame(5, 5);
        frame(0, 4);
        chk("relock_2", 32'(locked), 1);

        run_line(5, HT, 0, 300);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_any", 32'(|{rgb_out, de_out, x, y, frame_start,
            h_total, h_active, v_total, v_active, locked, overflow}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_line(5, HT, 300, HT);
        frame(0, 5);
        frame(0, 4);
        chk("post_rst_e2", 32'(locked), 0);
        frame(5, 5);
        frame(0, 4);
        chk("post_rst_e3", 32'(locked), 1);
        chk_meas("post_rst");

        repeat (2100) begin
            @(negedge clk);
            hsync_in = 1'b1;
            vsync_in = 1'b1;
            de_in = 1'b0;
        end
        repeat (4) begin
            @(negedge clk);
            hsync_in = 1'b0;
        end
        repeat (4) begin
            @(negedge clk);
            hsync_in = 1'b1;
        end
        chk("sat_ht", 32'(h_total), 2047);
        chk("sat_ha", 32'(h_active), 0);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_lock", 32'(locked), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
